// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared encodings for the control unit: opcodes, FSM states,
//               ALU operations and instruction-register field positions.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_ADDI = 4'h6,
    OP_LDI  = 4'h7,
    OP_LD   = 4'h8,
    OP_ST   = 4'h9,
    OP_BEQ  = 4'hA,
    OP_JMP  = 4'hB,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_PASS_B = 3'd5
  } alu_op_e;

  localparam int c_IR_W   = 24;
  localparam int c_OP_HI  = 23;
  localparam int c_OP_LO  = 20;
  localparam int c_RD_HI  = 19;
  localparam int c_RD_LO  = 16;
  localparam int c_RS1_HI = 15;
  localparam int c_RS1_LO = 12;
  localparam int c_RS2_HI = 11;
  localparam int c_RS2_LO = 8;
  localparam int c_OFF_HI = 7;
  localparam int c_OFF_LO = 0;

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_decoder
// Description : Pure combinational opcode-to-control decode for control_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] alu_op,
  output logic       alu_src_imm,
  output logic       wb_alu,
  output logic       is_ld,
  output logic       is_st,
  output logic       is_beq,
  output logic       is_jmp,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    wb_alu      = 1'b0;
    is_ld       = 1'b0;
    is_st       = 1'b0;
    is_beq      = 1'b0;
    is_jmp      = 1'b0;
    is_halt     = 1'b0;
    is_illegal  = 1'b0;
    case (opcode)
      OP_NOP:  ;
      OP_ADD:  wb_alu = 1'b1;
      OP_SUB:  begin alu_op = ALU_SUB; wb_alu = 1'b1; end
      OP_AND:  begin alu_op = ALU_AND; wb_alu = 1'b1; end
      OP_OR:   begin alu_op = ALU_OR;  wb_alu = 1'b1; end
      OP_XOR:  begin alu_op = ALU_XOR; wb_alu = 1'b1; end
      OP_ADDI: begin alu_src_imm = 1'b1; wb_alu = 1'b1; end
      OP_LDI:  begin alu_op = ALU_PASS_B; alu_src_imm = 1'b1; wb_alu = 1'b1; end
      // Loads and stores form their address as rs1 + imm on the ALU.
      OP_LD:   begin alu_src_imm = 1'b1; is_ld = 1'b1; end
      OP_ST:   begin alu_src_imm = 1'b1; is_st = 1'b1; end
      OP_BEQ:  begin alu_op = ALU_SUB; is_beq = 1'b1; end
      OP_JMP:  is_jmp = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Multi-cycle CPU control: holds the instruction register and
//               the FETCH/DECODE/EXECUTE/MEM/WRITEBACK/HALT sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [23:0]       instr,
  input  logic              zero,
  output logic              pc_en,
  output logic              pc_load,
  output logic [7:0]        pc_offset,
  output logic [3:0]        rd,
  output logic [3:0]        rs1,
  output logic [3:0]        rs2,
  output logic [DATA_W-1:0] imm,
  output logic [2:0]        alu_op,
  output logic              alu_src_imm,
  output logic              reg_we,
  output logic              mem_re,
  output logic              mem_we,
  output logic              wb_sel,
  output logic [2:0]        state,
  output logic              halted,
  output logic              illegal
);

  state_e              r_state;
  state_e              w_next;
  logic [c_IR_W-1:0]   r_ir;
  logic                r_halted;
  logic                r_illegal;

  logic w_wb_alu, w_is_ld, w_is_st, w_is_beq, w_is_jmp, w_is_halt, w_is_illegal;

  // The PC counter lives outside; a degenerate width has nothing to drive.
  if (PC_W < 1) begin : g_pc_w_invalid
  end

  instr_decoder u_dec (
    .opcode      (r_ir[c_OP_HI:c_OP_LO]),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .wb_alu      (w_wb_alu),
    .is_ld       (w_is_ld),
    .is_st       (w_is_st),
    .is_beq      (w_is_beq),
    .is_jmp      (w_is_jmp),
    .is_halt     (w_is_halt),
    .is_illegal  (w_is_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir      <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (r_state == S_FETCH) r_ir <= instr;
      if (r_state == S_DECODE && w_is_illegal) r_illegal <= 1'b1;
      if (w_next == S_HALT) r_halted <= 1'b1;
    end
  end

  always_comb begin
    w_next  = r_state;
    pc_en   = 1'b0;
    pc_load = 1'b0;
    reg_we  = 1'b0;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = (w_is_halt || w_is_illegal) ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
        if (w_wb_alu) begin
          w_next = S_WRITEBACK;
        end else if (w_is_ld || w_is_st) begin
          w_next = S_MEM;
        end else begin
          // NOP, BEQ and JMP retire here.
          w_next  = S_FETCH;
          pc_en   = 1'b1;
          pc_load = w_is_jmp | (w_is_beq & zero);
        end
      end
      S_MEM: begin
        if (w_is_ld) begin
          mem_re = 1'b1;
          w_next = S_WRITEBACK;
        end else begin
          mem_we = 1'b1;
          pc_en  = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_WRITEBACK: begin
        reg_we = 1'b1;
        pc_en  = 1'b1;
        w_next = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  assign pc_offset = r_ir[c_OFF_HI:c_OFF_LO];
  assign rd        = r_ir[c_RD_HI:c_RD_LO];
  assign rs1       = r_ir[c_RS1_HI:c_RS1_LO];
  assign rs2       = r_ir[c_RS2_HI:c_RS2_LO];
  assign imm       = {{(DATA_W-8){r_ir[c_OFF_HI]}}, r_ir[c_OFF_HI:c_OFF_LO]};
  assign wb_sel    = w_is_ld;
  assign state     = r_state;
  assign halted    = r_halted;
  assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Scoreboard bench for control_unit with an instruction memory
//               and PC model around the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] instr;
  logic        zero;
  logic        pc_en, pc_load, alu_src_imm, reg_we, mem_re, mem_we, wb_sel;
  logic        halted, illegal;
  logic [7:0]  pc_offset;
  logic [3:0]  rd, rs1, rs2;
  logic [15:0] imm;
  logic [2:0]  alu_op, state;

  control_unit #(.DATA_W(16), .PC_W(8)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero),
    .pc_en(pc_en), .pc_load(pc_load), .pc_offset(pc_offset),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .reg_we(reg_we), .mem_re(mem_re),
    .mem_we(mem_we), .wb_sel(wb_sel), .state(state),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic       pe, pl, rw, mr, mw, wb;
    logic [7:0] off;
    logic [3:0] rd;
    bit         chk_alu;
    logic [2:0] alu;
    logic       src;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc;
  logic [7:0]  pc;
  logic [23:0] imem [256];

  assign instr = imem[pc];
  assign zero  = (pc == 8'd1);

  // External PC and per-instruction cycle index (1 = first FETCH after reset)
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pc  <= 8'd0;
      cyc <= 1;
    end else begin
      cyc <= cyc + 1;
      if (pc_en) pc <= pc_load ? pc + pc_offset : pc + 8'd1;
    end
  end

  always @(negedge clk) begin
    if (!reset && (pc_en || pc_load || reg_we || mem_re || mem_we)) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected cyc=%0d state=%0d pe=%b pl=%b rw=%b mr=%b mw=%b required none",
                 cyc, state, pc_en, pc_load, reg_we, mem_re, mem_we);
      end else begin
        mon_e = sb_q.pop_front();
        if (cyc != mon_e.cyc || state != mon_e.st || pc_en != mon_e.pe || pc_load != mon_e.pl ||
            reg_we != mon_e.rw || mem_re != mon_e.mr || mem_we != mon_e.mw || wb_sel != mon_e.wb ||
            pc_offset != mon_e.off || rd != mon_e.rd || imm != {{8{mon_e.off[7]}}, mon_e.off} ||
            (mon_e.chk_alu && (alu_op != mon_e.alu || alu_src_imm != mon_e.src))) begin
          failures++;
          $display("FAIL sb_event actual cyc=%0d st=%0d pe=%b pl=%b rw=%b mr=%b mw=%b wb=%b off=%h rd=%h imm=%h alu=%0d src=%b required cyc=%0d st=%0d pe=%b pl=%b rw=%b mr=%b mw=%b wb=%b off=%h rd=%h alu=%0d src=%b",
                   cyc, state, pc_en, pc_load, reg_we, mem_re, mem_we, wb_sel, pc_offset, rd, imm,
                   alu_op, alu_src_imm, mon_e.cyc, mon_e.st, mon_e.pe, mon_e.pl, mon_e.rw, mon_e.mr,
                   mon_e.mw, mon_e.wb, mon_e.off, mon_e.rd, mon_e.alu, mon_e.src);
        end
      end
    end
  end

  task automatic expect_ev(input int c, input logic [2:0] st, input logic pe, input logic pl,
                           input logic rw, input logic mr, input logic mw, input logic wb,
                           input logic [7:0] off, input logic [3:0] r, input bit ca,
                           input logic [2:0] al, input logic sr);
    exp_t x;
    x.cyc = c; x.st = st; x.pe = pe; x.pl = pl; x.rw = rw; x.mr = mr; x.mw = mw; x.wb = wb;
    x.off = off; x.rd = r; x.chk_alu = ca; x.alu = al; x.src = sr;
    sb_q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (cyc != n && k < 300);
    if (cyc != n) begin
      checks++;
      failures++;
      $display("FAIL wait_cyc actual=%0d required=%0d", cyc, n);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 24'h000000;
    imem[0]   = 24'h131200;  // ADD  r3 = r1 + r2
    imem[1]   = 24'hA000FC;  // BEQ  -4, taken (zero=1 at pc 1)
    imem[253] = 24'hA000FC;  // BEQ  -4, not taken
    imem[254] = 24'h851004;  // LD   r5 = M[r1+4]
    imem[255] = 24'hB00003;  // JMP  +3, wraps to 2
    imem[2]   = 24'h902500;  // ST   M[r2] = r5
    imem[3]   = 24'h671085;  // ADDI r7 = r1 + sext(85)
    imem[4]   = 24'h780012;  // LDI  r8 = 0x12
    imem[5]   = 24'h000000;  // NOP
    imem[6]   = 24'hD00000;  // illegal

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(state), 32'(S_FETCH));
    chk("reset_strobes", {27'd0, pc_en, pc_load, reg_we, mem_re, mem_we}, 32'd0);
    chk("reset_flags", {30'd0, halted, illegal}, 32'd0);
    chk("reset_ir", {12'd0, rd, rs1, rs2, pc_offset}, 32'd0);

    expect_ev(4,  S_WRITEBACK, 1, 0, 1, 0, 0, 0, 8'h00, 4'd3, 1, ALU_ADD, 0);
    expect_ev(7,  S_EXECUTE,   1, 1, 0, 0, 0, 0, 8'hFC, 4'd0, 1, ALU_SUB, 0);
    expect_ev(10, S_EXECUTE,   1, 0, 0, 0, 0, 0, 8'hFC, 4'd0, 1, ALU_SUB, 0);
    expect_ev(14, S_MEM,       0, 0, 0, 1, 0, 1, 8'h04, 4'd5, 0, ALU_ADD, 0);
    expect_ev(15, S_WRITEBACK, 1, 0, 1, 0, 0, 1, 8'h04, 4'd5, 0, ALU_ADD, 0);
    expect_ev(18, S_EXECUTE,   1, 1, 0, 0, 0, 0, 8'h03, 4'd0, 0, ALU_ADD, 0);
    expect_ev(22, S_MEM,       1, 0, 0, 0, 1, 0, 8'h00, 4'd0, 0, ALU_ADD, 0);
    expect_ev(26, S_WRITEBACK, 1, 0, 1, 0, 0, 0, 8'h85, 4'd7, 1, ALU_ADD, 1);
    expect_ev(30, S_WRITEBACK, 1, 0, 1, 0, 0, 0, 8'h12, 4'd8, 1, ALU_PASS_B, 1);
    expect_ev(33, S_EXECUTE,   1, 0, 0, 0, 0, 0, 8'h00, 4'd0, 0, ALU_ADD, 0);

    @(posedge clk);
    #1 reset = 1'b0;

    wait_cyc(1);  chk("add_c1_fetch",  32'(state), 32'(S_FETCH));
    wait_cyc(2);  chk("add_c2_decode", 32'(state), 32'(S_DECODE));
    wait_cyc(3);  chk("add_c3_exec",   32'(state), 32'(S_EXECUTE));
    wait_cyc(35); chk("illegal_decode", {29'd0, state}, 32'(S_DECODE));
    wait_cyc(36);
    chk("halt_entry", 32'(state), 32'(S_HALT));
    chk("halt_flags", {30'd0, halted, illegal}, 32'd3);
    wait_cyc(57);
    chk("halt_absorbing", {28'd0, halted, state}, {28'd0, 1'b1, S_HALT});
    chk("run1_drained", 32'(sb_q.size()), 32'd0);

    // Second pass: abort an LD while it sits in MEM.
    expect_ev(4,  S_WRITEBACK, 1, 0, 1, 0, 0, 0, 8'h00, 4'd3, 1, ALU_ADD, 0);
    expect_ev(7,  S_EXECUTE,   1, 1, 0, 0, 0, 0, 8'hFC, 4'd0, 1, ALU_SUB, 0);
    expect_ev(10, S_EXECUTE,   1, 0, 0, 0, 0, 0, 8'hFC, 4'd0, 1, ALU_SUB, 0);
    reset = 1'b1;
    #1;
    chk("halt_cleared_by_reset", {29'd0, halted, illegal, 1'b0}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_cyc(13);
    chk("ld_exec", 32'(state), 32'(S_EXECUTE));
    @(posedge clk);
    #2;
    chk("ld_in_mem", 32'(state), 32'(S_MEM));
    reset = 1'b1;
    #1;
    chk("abort_state", 32'(state), 32'(S_FETCH));
    chk("abort_strobes", {27'd0, pc_en, pc_load, reg_we, mem_re, mem_we}, 32'd0);
    chk("abort_ir", {12'd0, rd, rs1, rs2, pc_offset}, 32'd0);
    chk("run2_drained", 32'(sb_q.size()), 32'd0);

    expect_ev(4,  S_WRITEBACK, 1, 0, 1, 0, 0, 0, 8'h00, 4'd3, 1, ALU_ADD, 0);
    expect_ev(7,  S_EXECUTE,   1, 1, 0, 0, 0, 0, 8'hFC, 4'd0, 1, ALU_SUB, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_cyc(2);
    chk("restart_fetch_pc0", {24'd0, rd, rs1}, {24'd0, 4'd3, 4'd1});
    wait_cyc(8);
    chk("run3_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
